// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings, stage-4 FSM states and the
// stage-latch payload carried from stage 3 into stage 4.
package pipe_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_LOAD  = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_STORE = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] z;
        logic [DATA_W-1:0] md;
    } stage_regs_t;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without an ack; expire_c flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline stage 4: performs loads/stores over a req/ack data-memory port and
// registers the stage-4 latches for writeback, stalling stage 3 while busy.
module memory_access_stage
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ir3_output,
    input  logic [DATA_W-1:0] pc3_output,
    input  logic [DATA_W-1:0] z3_output,
    input  logic [DATA_W-1:0] md3_output,
    input  logic              valid3,
    output logic              stall,
    output logic [DATA_W-1:0] ir4_output,
    output logic [DATA_W-1:0] pc4_output,
    output logic [DATA_W-1:0] z4_output,
    output logic [DATA_W-1:0] md4_output,
    output logic [DATA_W-1:0] read_data,
    output logic              valid4,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              misalign_err,
    output logic              bus_err
);

    state_t            state_q, state_d;
    stage_regs_t       lat_q, lat_d;
    stage_regs_t       s4_q, s4_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid4_q, valid4_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              cnt_clear_c;
    logic              cnt_en_c;
    logic              cnt_expire_c;
    logic [OPC_W-1:0]  opc3_c;
    stage_regs_t       in3_c;

    assign opc3_c = ir3_output[OPC_MSB:OPC_LSB];
    assign in3_c  = {ir3_output, pc3_output, z3_output, md3_output};

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear_c),
        .enable   (cnt_en_c),
        .expire_c (cnt_expire_c)
    );

    // Next-state and register updates; the status pulses default low each cycle.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        s4_d        = s4_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        valid4_d    = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid3) begin
                    if (!is_mem_op(opc3_c)) begin
                        s4_d     = in3_c;
                        rdata_d  = '0;
                        valid4_d = 1'b1;
                    end else if (z3_output[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        lat_d       = in3_c;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (opc3_c == OPC_STORE);
                        cnt_clear_c = 1'b1;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    s4_d      = lat_q;
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    valid4_d  = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_expire_c) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            s4_q       <= '0;
            rdata_q    <= '0;
            valid4_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            s4_q       <= s4_d;
            rdata_q    <= rdata_d;
            valid4_q   <= valid4_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall        = (state_q != ST_IDLE);
    assign ir4_output   = s4_q.ir;
    assign pc4_output   = s4_q.pc;
    assign z4_output    = s4_q.z;
    assign md4_output   = s4_q.md;
    assign read_data    = rdata_q;
    assign valid4       = valid4_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = lat_q.z;
    assign mem_wdata    = lat_q.md;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
